// File: rtl/register.sv
// Clocked WIDTH-bit storage register with synchronous active-high reset on rst_n
// and a load enable; out is the registered contents with no combinational path.
module register #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next value: capture data when loading, otherwise hold.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = data;
    end
  end

  // rst_n is an active-high synchronous reset and takes priority over load.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      value_q <= RESET_VALUE;
    end else begin
      value_q <= value_d;
    end
  end

  assign out = value_q;

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register: directed scenarios plus randomized traffic
// against a behavioural model, on a default instance and a 12-bit instance.
module tb_register;

  localparam int unsigned      W   = 8;
  localparam int unsigned      W2  = 12;
  localparam logic [W2-1:0]    RV2 = 12'h5A3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [W-1:0]  data;
  logic [W-1:0]  out;
  logic [W2-1:0] data2;
  logic [W2-1:0] out2;

  int            errors = 0;
  int            checks = 0;
  logic [W-1:0]  exp_v;
  logic [W2-1:0] exp_v2;

  always #5 clk = ~clk;

  register u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .data  (data),
    .out   (out)
  );

  register #(.WIDTH(W2), .RESET_VALUE(RV2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .data  (data2),
    .out   (out2)
  );

  // Drive on the falling edge, advance the model at the rising edge, settle 1 unit.
  task automatic cycle(input logic r, input logic l, input logic [W-1:0] d,
                       input logic [W2-1:0] d2);
    @(negedge clk);
    rst_n = r;
    load  = l;
    data  = d;
    data2 = d2;
    @(posedge clk);
    if (r) begin
      exp_v  = '0;
      exp_v2 = RV2;
    end else if (l) begin
      exp_v  = d;
      exp_v2 = d2;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 8'h00, 12'h000);
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: got %h expected %h", out, 8'h00);
    end
    checks++;
    if (out2 !== RV2) begin
      errors++;
      $display("FAIL reset_out_w12: got %h expected %h", out2, RV2);
    end
    // After release, value holds until a load.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, W'($urandom), W2'($urandom));
      checks++;
      if (out !== 8'h00 || out2 !== RV2) begin
        errors++;
        $display("FAIL reset_hold: got %h/%h expected %h/%h", out, out2, 8'h00, RV2);
      end
    end
  endtask

  task automatic test_load();
    cycle(1'b0, 1'b1, 8'h55, 12'hABC);
    checks++;
    if (out !== 8'h55 || out2 !== 12'hABC) begin
      errors++;
      $display("FAIL load_55: got %h/%h expected %h/%h", out, out2, 8'h55, 12'hABC);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = W'($urandom);
      cycle(1'b0, 1'b1, v, 12'(i));
      checks++;
      if (out !== v || out2 !== 12'(i)) begin
        errors++;
        $display("FAIL b2b_load%0d: got %h/%h expected %h/%h", i, out, out2, v, 12'(i));
      end
    end
    cycle(1'b0, 1'b1, 8'hFF, 12'hFFF);
    checks++;
    if (out !== 8'hFF || out2 !== 12'hFFF) begin
      errors++;
      $display("FAIL b2b_ones: got %h/%h expected FF/FFF", out, out2);
    end
    cycle(1'b0, 1'b1, 8'hAA, 12'h000);
    checks++;
    if (out !== 8'hAA || out2 !== 12'h000) begin
      errors++;
      $display("FAIL b2b_AA: got %h/%h expected AA/000", out, out2);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 8'hCC, 12'hCCC);
      checks++;
      if (out !== 8'hAA || out2 !== 12'h000) begin
        errors++;
        $display("FAIL hold%0d: got %h/%h expected AA/000", i, out, out2);
      end
    end
  endtask

  task automatic test_reset_priority();
    cycle(1'b1, 1'b1, 8'hFF, 12'hFFF);
    checks++;
    if (out !== 8'h00 || out2 !== RV2) begin
      errors++;
      $display("FAIL reset_priority: got %h/%h expected 00/%h", out, out2, RV2);
    end
  endtask

  task automatic test_edge_only();
    cycle(1'b0, 1'b1, 8'h55, 12'h055);
    checks++;
    if (out !== 8'h55) begin
      errors++;
      $display("FAIL edge_setup: got %h expected 55", out);
    end
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    #2;
    checks++;
    if (out !== 8'h55 || out2 !== 12'h055) begin
      errors++;
      $display("FAIL edge_mid_reset: got %h/%h expected 55/055", out, out2);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 8'h55 || out2 !== 12'h055) begin
      errors++;
      $display("FAIL edge_after_toggle: got %h/%h expected 55/055", out, out2);
    end
  endtask

  task automatic test_random();
    logic         r;
    logic         l;
    logic [W-1:0] d;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(7) == 0);
      l = ($urandom_range(1) == 1);
      d = W'($urandom);
      cycle(r, l, d, W2'($urandom));
      checks++;
      if (out !== exp_v || out2 !== exp_v2) begin
        errors++;
        $display("FAIL random%0d: got %h/%h expected %h/%h", i, out, out2, exp_v, exp_v2);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    data   = '0;
    data2  = '0;
    exp_v  = 'x;
    exp_v2 = 'x;
    test_reset();
    test_load();
    test_back_to_back();
    test_hold();
    test_reset_priority();
    test_edge_only();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, giving the data and output width in bits.
REQ-002 The block SHALL expose parameter RESET_VALUE, default 0 (WIDTH bits), giving the value loaded into the register on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port load, input, 1 bit: load enable, active-high.
REQ-006 The block SHALL have port data, input, WIDTH bits: the value to store when load is sampled high.
REQ-007 The block SHALL have port out, output, WIDTH bits: the current register contents.
REQ-008 The block SHALL use one clock and a synchronous, active-high reset on rst_n; no asynchronous or negative-edge logic is permitted.

Function
REQ-009 The block SHALL hold a WIDTH-bit storage register whose value drives out directly.
- out SHALL be a pure register output, with no combinational path from data, load or rst_n.
REQ-010 On each rising clk edge, the block SHALL select the next register value by priority:
- rst_n=1: the register takes RESET_VALUE.
- rst_n=0 and load=1: the register takes data.
- otherwise: the register holds its value.
REQ-011 The latency SHALL be one cycle: data sampled at edge N SHALL appear on out immediately after edge N and remain until the next qualifying edge.
REQ-012 When load=0, changes on data SHALL NOT affect out.
REQ-013 When load is held high over consecutive edges, the block SHALL capture data on every edge.
REQ-014 When rst_n=1 and load=1 at the same edge, reset SHALL win and the register SHALL take RESET_VALUE.
REQ-015 Reset SHALL act only at a rising clk edge; asserting or releasing rst_n between edges SHALL NOT change out.
REQ-016 All WIDTH bits SHALL be stored independently.
- There is no arithmetic, masking, truncation or extension.
- Any value from 0 to 2^WIDTH-1 SHALL be stored and reproduced exactly.
REQ-017 Before the first reset edge, out is unspecified (X in simulation).
- The block SHALL NOT rely on an initial-value assignment.

Reset
REQ-018 After any rising clk edge with rst_n=1, out SHALL equal RESET_VALUE (00h at default parameters).
REQ-019 After rst_n returns to 0, the register SHALL hold RESET_VALUE until the first edge with load=1.
REQ-020 Reset applied mid-operation, with a loaded value present, SHALL overwrite it with RESET_VALUE at the next edge.

Verification
All stimulus SHALL change on the falling clk edge; checks are made after the following rising edge.
REQ-021 Reset: rst_n=1, load=0, data=00h -> out=00h.
REQ-022 Load 55h: rst_n=0, load=1, data=55h -> out=55h after one edge.
REQ-023 Back-to-back load: load=1, data=AAh on the next cycle -> out=AAh.
REQ-024 Hold: load=0, data=CCh -> out remains AAh for all subsequent edges while load=0.
REQ-025 Reset priority: out=AAh, then rst_n=1 with load=1 and data=FFh -> out=00h.
REQ-026 Edge-only timing: toggle rst_n high then low between two rising edges while out=55h -> out stays 55h.
